// File: rtl/bus_pkg.sv
// Shared definitions for the CPU-to-device bus router.
// Holds the router FSM state encoding, well-known device indices and the
// data pattern returned on an errored access (unmapped device or timeout).
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Fixed device slots on the router's device side
    localparam int DEV_MEM = 0;
    localparam int DEV_FP  = 1;

    // Read data returned on any errored response; sliced to the bus width
    localparam logic [63:0] ERR_DATA = {64{1'b1}};

endpackage

// File: rtl/bus_addr_decode.sv
// Device select decode for the bus router (purely combinational).
// Ports: dev_field  - top DEV_BITS of the CPU address
//        dev_onehot - one-hot device select (all zero when unmapped)
//        mapped     - high when the index addresses an attached device
module bus_addr_decode #(
    parameter int DEV_BITS = 4,
    parameter int NUM_DEV  = 4
) (
    input  logic [DEV_BITS-1:0] dev_field,
    output logic [NUM_DEV-1:0]  dev_onehot,
    output logic                mapped
);

    always_comb begin
        dev_onehot = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            dev_onehot[i] = (dev_field == DEV_BITS'(i));
        end
    end

    // One extra bit so NUM_DEV == 2**DEV_BITS compares correctly
    assign mapped = ({1'b0, dev_field} < (DEV_BITS + 1)'(NUM_DEV));

endmodule

// File: rtl/data_bus_router.sv
// CPU-to-device bus router: decodes the top address bits to a device, runs a
// single outstanding access per CPU request and returns a registered response.
// Ports: Clock/Reset (async active-high); CPU side ReadData/WriteData/DataAddr/
//        BusIn -> BusOut/Waitreq/BusErr; device side one-hot DevRead/DevWrite,
//        DevAddr, DevWdata, packed DevRdata and DevWaitreq.
// Optional: DATA_BUS_ROUTER_TIMEOUT_EN aborts an access after TIMEOUT cycles.
module data_bus_router
    import bus_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int DEV_BITS = 4,
    parameter int NUM_DEV  = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       ReadData,
    input  logic                       WriteData,
    input  logic [ADDR_W-1:0]          DataAddr,
    input  logic [DATA_W-1:0]          BusIn,
    output logic [DATA_W-1:0]          BusOut,
    output logic                       Waitreq,
    output logic                       BusErr,
    output logic [NUM_DEV-1:0]         DevRead,
    output logic [NUM_DEV-1:0]         DevWrite,
    output logic [ADDR_W-DEV_BITS-1:0] DevAddr,
    output logic [DATA_W-1:0]          DevWdata,
    input  logic [NUM_DEV*DATA_W-1:0]  DevRdata,
    input  logic [NUM_DEV-1:0]         DevWaitreq
);

    if (NUM_DEV > (1 << DEV_BITS) || TIMEOUT < 1) begin : g_param_check
        $error("data_bus_router: NUM_DEV exceeds 2**DEV_BITS or TIMEOUT < 1");
    end

    state_t              state, state_nxt;
    logic [NUM_DEV-1:0]  dec_onehot;
    logic                dec_mapped;
    logic [NUM_DEV-1:0]  sel_oh_q;
    logic                is_wr_q;
    logic                start, access_done, access_abort;
    logic                dev_wait;
    logic [DATA_W-1:0]   rd_sel;
    logic                tmo_hit;

    bus_addr_decode #(
        .DEV_BITS (DEV_BITS),
        .NUM_DEV  (NUM_DEV)
    ) u_decode (
        .dev_field  (DataAddr[ADDR_W-1 -: DEV_BITS]),
        .dev_onehot (dec_onehot),
        .mapped     (dec_mapped)
    );

    // Latched one-hot select lets us avoid a variable index into device buses
    assign dev_wait = |(DevWaitreq & sel_oh_q);

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (sel_oh_q[i]) begin
                rd_sel = rd_sel | DevRdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef DATA_BUS_ROUTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;

    // Hit on the TIMEOUT-th ACCESS cycle (counter starts at 0 on entry)
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tmo_cnt <= '0;
        end else if (start) begin
            tmo_cnt <= '0;
        end else if (state == ST_ACCESS) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        Waitreq      = 1'b0;
        start        = 1'b0;
        access_done  = 1'b0;
        access_abort = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ReadData || WriteData) begin
                    Waitreq   = 1'b1;
                    start     = 1'b1;
                    state_nxt = dec_mapped ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                Waitreq = 1'b1;
                if (!dev_wait) begin
                    access_done = 1'b1;
                    state_nxt   = ST_RESP;
                end else if (tmo_hit) begin
                    access_abort = 1'b1;
                    state_nxt    = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // Stall is released the moment reset is applied, even with a request held
        if (Reset) begin
            Waitreq = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sel_oh_q <= '0;
            is_wr_q  <= 1'b0;
            DevAddr  <= '0;
            DevWdata <= '0;
            DevRead  <= '0;
            DevWrite <= '0;
            BusOut   <= '0;
            BusErr   <= 1'b0;
        end else begin
            if (start) begin
                sel_oh_q <= dec_onehot;
                // Write wins when both requests are raised together
                is_wr_q  <= WriteData;
                DevAddr  <= DataAddr[ADDR_W-DEV_BITS-1:0];
                DevWdata <= BusIn;
                if (dec_mapped) begin
                    DevRead  <= WriteData ? '0 : dec_onehot;
                    DevWrite <= WriteData ? dec_onehot : '0;
                end else begin
                    BusOut <= ERR_DATA[DATA_W-1:0];
                    BusErr <= 1'b1;
                end
            end
            if (access_done) begin
                DevRead  <= '0;
                DevWrite <= '0;
                if (!is_wr_q) begin
                    BusOut <= rd_sel;
                end
            end
            if (access_abort) begin
                DevRead  <= '0;
                DevWrite <= '0;
                BusOut   <= ERR_DATA[DATA_W-1:0];
                BusErr   <= 1'b1;
            end
            if (state == ST_RESP) begin
                BusErr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_bus_router.sv
// Bench for data_bus_router with default parameters (16-bit buses, 4 devices).
// Applies a table of single transactions, then stall and reset-mid-access
// sequences; build with DATA_BUS_ROUTER_TIMEOUT_EN to exercise the abort path.
module tb_data_bus_router;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReadData, WriteData;
    logic [15:0] DataAddr, BusIn;
    logic [15:0] BusOut;
    logic        Waitreq, BusErr;
    logic [3:0]  DevRead, DevWrite;
    logic [11:0] DevAddr;
    logic [15:0] DevWdata;
    logic [63:0] DevRdata;
    logic [3:0]  DevWaitreq;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    data_bus_router #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .DEV_BITS (4),
        .NUM_DEV  (4),
        .TIMEOUT  (15)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .ReadData   (ReadData),
        .WriteData  (WriteData),
        .DataAddr   (DataAddr),
        .BusIn      (BusIn),
        .BusOut     (BusOut),
        .Waitreq    (Waitreq),
        .BusErr     (BusErr),
        .DevRead    (DevRead),
        .DevWrite   (DevWrite),
        .DevAddr    (DevAddr),
        .DevWdata   (DevWdata),
        .DevRdata   (DevRdata),
        .DevWaitreq (DevWaitreq)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          wait_n;       // ACCESS cycles the device holds DevWaitreq
        logic [15:0] exp_out;
        logic        exp_err;
        logic [3:0]  exp_oh;
        int          exp_strobes;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Starts just after a rising edge with the router idle; ends the same way.
    task automatic run_txn(input vec_t v);
        int  s;
        bit  done;
        s    = 0;
        done = 1'b0;
        ReadData   = v.rd;
        WriteData  = v.wr;
        DataAddr   = v.addr;
        BusIn      = v.wdata;
        DevWaitreq = (v.wait_n >= 1) ? 4'hF : 4'h0;
        @(negedge Clock);
        chk("req_waitreq", {31'd0, Waitreq}, 32'd1);
        chk("req_no_strobe", {28'd0, DevRead | DevWrite}, 32'd0);
        chk("req_buserr", {31'd0, BusErr}, 32'd0);
        for (int c = 1; c <= 40 && !done; c++) begin
            @(posedge Clock);
            #1;
            // Request dropped mid-transaction: the access must still complete
            ReadData   = 1'b0;
            WriteData  = 1'b0;
            DevWaitreq = (s + 1 <= v.wait_n) ? 4'hF : 4'h0;
            @(negedge Clock);
            if (!Waitreq) begin
                done = 1'b1;
                chk("resp_cycle", c, v.exp_strobes + 1);
                chk("resp_busout", {16'd0, BusOut}, {16'd0, v.exp_out});
                chk("resp_buserr", {31'd0, BusErr}, {31'd0, v.exp_err});
                chk("resp_no_strobe", {28'd0, DevRead | DevWrite}, 32'd0);
            end else begin
                s++;
                chk("acc_devread", {28'd0, DevRead}, {28'd0, v.wr ? 4'h0 : v.exp_oh});
                chk("acc_devwrite", {28'd0, DevWrite}, {28'd0, v.wr ? v.exp_oh : 4'h0});
                chk("acc_buserr", {31'd0, BusErr}, 32'd0);
                if (s == 1) begin
                    chk("acc_devaddr", {20'd0, DevAddr}, {20'd0, v.addr[11:0]});
                    if (v.wr) chk("acc_devwdata", {16'd0, DevWdata}, {16'd0, v.wdata});
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL resp_never_seen got waitreq %b want 0 within 40 cycles", Waitreq);
        end
        chk("strobe_cycles", s, v.exp_strobes);
        @(posedge Clock);
        #1;
        DevWaitreq = 4'h0;
        @(negedge Clock);
        chk("idle_waitreq", {31'd0, Waitreq}, 32'd0);
        chk("idle_buserr", {31'd0, BusErr}, 32'd0);
        chk("idle_busout_hold", {16'd0, BusOut}, {16'd0, v.exp_out});
        @(posedge Clock);
        #1;
    endtask

    initial begin
        vec_t sv;
        //            rd    wr    addr      wdata     wait exp_out   err   oh     strobes
        vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 0, 16'h1234, 1'b0, 4'b0001, 1};
        vecs[1] = '{1'b0, 1'b1, 16'h1002, 16'hBEEF, 3, 16'h1234, 1'b0, 4'b0010, 4};
        vecs[2] = '{1'b1, 1'b0, 16'h7000, 16'h0000, 0, 16'hFFFF, 1'b1, 4'b0000, 0};
        vecs[3] = '{1'b1, 1'b0, 16'h2ABC, 16'h0000, 1, 16'h3333, 1'b0, 4'b0100, 2};
        vecs[4] = '{1'b1, 1'b1, 16'h3005, 16'h5A5A, 0, 16'h3333, 1'b0, 4'b1000, 1};
        vecs[5] = '{1'b0, 1'b1, 16'hF123, 16'h1111, 0, 16'hFFFF, 1'b1, 4'b0000, 0};
        vecs[6] = '{1'b1, 1'b0, 16'h1FFF, 16'h0000, 2, 16'hABCD, 1'b0, 4'b0010, 3};
        vecs[7] = '{1'b1, 1'b0, 16'h4000, 16'h0000, 0, 16'hFFFF, 1'b1, 4'b0000, 0};
        vecs[8] = '{1'b1, 1'b0, 16'h3FFF, 16'h0000, 0, 16'h4444, 1'b0, 4'b1000, 1};

        Reset      = 1'b1;
        ReadData   = 1'b0;
        WriteData  = 1'b0;
        DataAddr   = 16'h0000;
        BusIn      = 16'h0000;
        DevRdata   = 64'h4444_3333_ABCD_1234;
        DevWaitreq = 4'h0;
        @(negedge Clock);
        chk("rst_busout", {16'd0, BusOut}, 32'd0);
        chk("rst_waitreq", {31'd0, Waitreq}, 32'd0);
        chk("rst_buserr", {31'd0, BusErr}, 32'd0);
        chk("rst_strobes", {24'd0, DevRead, DevWrite}, 32'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(posedge Clock);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i]);
        end

        // Device 0 never releases its wait request
`ifdef DATA_BUS_ROUTER_TIMEOUT_EN
        sv = '{1'b1, 1'b0, 16'h0020, 16'h0000, 100, 16'hFFFF, 1'b1, 4'b0001, 15};
`else
        sv = '{1'b1, 1'b0, 16'h0020, 16'h0000, 20, 16'h1234, 1'b0, 4'b0001, 21};
`endif
        run_txn(sv);

        // Reset in the middle of an ACCESS with the CPU still requesting
        ReadData   = 1'b1;
        DataAddr   = 16'h0010;
        DevWaitreq = 4'hF;
        @(posedge Clock);
        #1;
        @(posedge Clock);
        #1;
        @(negedge Clock);
        chk("mid_access_strobe", {28'd0, DevRead}, 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_devread", {28'd0, DevRead}, 32'd0);
        chk("arst_waitreq", {31'd0, Waitreq}, 32'd0);
        chk("arst_busout", {16'd0, BusOut}, 32'd0);
        chk("arst_buserr", {31'd0, BusErr}, 32'd0);
        @(posedge Clock);
        #1;
        ReadData   = 1'b0;
        DevWaitreq = 4'h0;
        Reset      = 1'b0;
        @(posedge Clock);
        #1;
        run_txn(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
